fb_arbiter: RTL and testbench

Frame-buffer access scheduler between the OV7725 capture path and the 640x480 LCD output path. Shares one burst-oriented memory command port between a write requester (camera line FIFO) and a read requester (display pixel FIFO that feeds the sync generator). The block:

- picks a winner per burst;
- issues one command with the address of the winner's next burst;
- holds the grant until the memory reports completion;
- keeps independent per-port frame address counters, realigned by each side's frame sync.

---
 rtl/fb_arbiter.sv | 121 ++++++++++++
 tb/tb_fb_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: burst scheduler sharing one memory command port between camera writes and display reads
module fb_arbiter #(
    parameter int BURST_LEN    = 64,
    parameter int FRAME_PIXELS = 307200,
    parameter int ADDR_W       = 19,
    parameter int WR_BASE      = 0,
    parameter int RD_BASE      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic              i_rd_req,
    input  logic              i_rd_urgent,
    input  logic              i_wr_frame_sync,
    input  logic              i_rd_frame_sync,
    output logic              o_wr_grant,
    output logic              o_rd_grant,
    output logic              o_mem_cmd_vld,
    output logic              o_mem_cmd_we,
    output logic [ADDR_W-1:0] o_mem_cmd_addr,
    input  logic              i_mem_cmd_rdy,
    input  logic              i_mem_done,
    output logic              o_wr_frame_done
);
    localparam logic [ADDR_W-1:0] BL = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FP = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] WB = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] RB = ADDR_W'(RD_BASE);

    typedef enum logic [1:0] {IDLE, CMD, BUSY} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_off, wr_off_n, rd_off, rd_off_n, addr_n, wr_nxt, rd_nxt;
    logic              wr_pend, wr_pend_n, rd_pend, rd_pend_n, last_wr, last_wr_n;
    logic              wr_grant_n, rd_grant_n, vld_n, we_n, frame_done_n;
    logic              rd_win, wr_win;

    // urgent read overrides; otherwise a tie goes to the port that did not win last
    assign rd_win = i_rd_req && (i_rd_urgent || !i_wr_req || last_wr);
    assign wr_win = i_wr_req && !rd_win;
    assign wr_nxt = wr_off + BL;
    assign rd_nxt = rd_off + BL;

    always_comb begin
        state_n      = state;
        wr_off_n     = wr_off;
        rd_off_n     = rd_off;
        wr_pend_n    = wr_pend;
        rd_pend_n    = rd_pend;
        last_wr_n    = last_wr;
        wr_grant_n   = o_wr_grant;
        rd_grant_n   = o_rd_grant;
        vld_n        = o_mem_cmd_vld;
        we_n         = o_mem_cmd_we;
        addr_n       = o_mem_cmd_addr;
        frame_done_n = 1'b0;
        if (i_wr_frame_sync) begin
            if (o_wr_grant) wr_pend_n = 1'b1;
            else wr_off_n = '0;
        end
        if (i_rd_frame_sync) begin
            if (o_rd_grant) rd_pend_n = 1'b1;
            else rd_off_n = '0;
        end
        if (state == IDLE && (wr_win || rd_win)) begin
            state_n    = CMD;
            wr_grant_n = wr_win;
            rd_grant_n = rd_win;
            vld_n      = 1'b1;
            we_n       = wr_win;
            addr_n     = wr_win ? WB + wr_off_n : RB + rd_off_n;
        end else if (state == CMD && i_mem_cmd_rdy) begin
            state_n   = BUSY;
            vld_n     = 1'b0;
            last_wr_n = o_wr_grant;
        end else if (state == BUSY && i_mem_done) begin
            state_n    = IDLE;
            wr_grant_n = 1'b0;
            rd_grant_n = 1'b0;
            // a pending frame sync restarts the frame instead of advancing
            if (o_wr_grant) begin
                wr_off_n     = (wr_pend_n || wr_nxt == FP) ? '0 : wr_nxt;
                frame_done_n = !wr_pend_n && wr_nxt == FP;
                wr_pend_n    = 1'b0;
            end else begin
                rd_off_n  = (rd_pend_n || rd_nxt == FP) ? '0 : rd_nxt;
                rd_pend_n = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            wr_off          <= '0;
            rd_off          <= '0;
            wr_pend         <= 1'b0;
            rd_pend         <= 1'b0;
            last_wr         <= 1'b0;
            o_wr_grant      <= 1'b0;
            o_rd_grant      <= 1'b0;
            o_mem_cmd_vld   <= 1'b0;
            o_mem_cmd_we    <= 1'b0;
            o_mem_cmd_addr  <= '0;
            o_wr_frame_done <= 1'b0;
        end else begin
            state           <= state_n;
            wr_off          <= wr_off_n;
            rd_off          <= rd_off_n;
            wr_pend         <= wr_pend_n;
            rd_pend         <= rd_pend_n;
            last_wr         <= last_wr_n;
            o_wr_grant      <= wr_grant_n;
            o_rd_grant      <= rd_grant_n;
            o_mem_cmd_vld   <= vld_n;
            o_mem_cmd_we    <= we_n;
            o_mem_cmd_addr  <= addr_n;
            o_wr_frame_done <= frame_done_n;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed stimulus with a cycle model of the scheduling rules and literal expectations
module tb_fb_arbiter;
    localparam int BL = 64;
    localparam int FP = 307200;
    localparam int WRB = 0;
    localparam int RDB = 0;

    logic clk = 0, rst_n = 0, wr_req = 0, rd_req = 0, urgent = 0;
    logic wr_sync = 0, rd_sync = 0, rdy = 0, done = 0;
    logic wr_grant, rd_grant, vld, we, fd;
    logic [18:0] addr;
    int errors = 0, checks = 0, fd_cnt = 0;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_req(wr_req), .i_rd_req(rd_req),
        .i_rd_urgent(urgent), .i_wr_frame_sync(wr_sync), .i_rd_frame_sync(rd_sync),
        .o_wr_grant(wr_grant), .o_rd_grant(rd_grant), .o_mem_cmd_vld(vld),
        .o_mem_cmd_we(we), .o_mem_cmd_addr(addr), .i_mem_cmd_rdy(rdy),
        .i_mem_done(done), .o_wr_frame_done(fd)
    );

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // model: port 0 = write, 1 = read; phase 0 idle, 1 command offered, 2 burst running
    int m_ph, m_own, m_last, m_win;
    int m_off[2];
    bit [1:0] m_pend, m_g, sy, rq;
    bit m_vld, m_we, m_fd, started = 0;
    int m_addr;

    always @(posedge clk) begin
        started = 1;
        if (!rst_n) begin
            m_ph = 0; m_own = 0; m_last = 1; m_off[0] = 0; m_off[1] = 0;
            m_pend = 0; m_g = 0; m_vld = 0; m_we = 0; m_addr = 0; m_fd = 0;
        end else begin
            sy = {rd_sync, wr_sync};
            rq = {rd_req, wr_req};
            m_fd = 0;
            for (int p = 0; p < 2; p++)
                if (sy[p]) begin
                    if (m_ph != 0 && m_own == p) m_pend[p] = 1;
                    else m_off[p] = 0;
                end
            if (m_ph == 0) begin
                m_win = (rq[1] && (urgent || !rq[0] || m_last == 0)) ? 1 : rq[0] ? 0 : -1;
                if (m_win >= 0) begin
                    m_own = m_win; m_ph = 1; m_g[m_win] = 1; m_vld = 1; m_we = (m_win == 0);
                    m_addr = ((m_win == 0 ? WRB : RDB) + m_off[m_win]) % (1 << 19);
                end
            end else if (m_ph == 1) begin
                if (rdy) begin m_vld = 0; m_ph = 2; m_last = m_own; end
            end else if (done) begin
                m_ph = 0; m_g = 0;
                if (m_pend[m_own]) m_off[m_own] = 0;
                else begin
                    m_off[m_own] += BL;
                    if (m_off[m_own] == FP) begin m_off[m_own] = 0; m_fd = (m_own == 0); end
                end
                m_pend[m_own] = 0;
            end
        end
    end

    always @(negedge clk) if (started) begin
        chk("wr_grant", wr_grant, m_g[0]);
        chk("rd_grant", rd_grant, m_g[1]);
        chk("cmd_vld", vld, m_vld);
        chk("frame_done", fd, m_fd);
        chk("one_grant", wr_grant & rd_grant, 0);
        if (m_vld) begin
            chk("cmd_we", we, m_we);
            chk("cmd_addr", addr, m_addr);
        end
        if (fd) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sm: 0 no sync, 1 owner's sync during the burst, 2 owner's sync with done
    task automatic burst(input int rdy_dly, input int dn_dly, input int sm,
                         output bit w, output int a, output bit stable);
        int n = 0;
        while (!vld && n < 50) begin tick(); n++; end
        if (!vld) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: got no command expected one within 50 cycles");
            w = 0; a = -1; stable = 0;
            return;
        end
        w = we; a = int'(addr); stable = 1;
        repeat (rdy_dly) begin
            tick();
            if (!vld || we != w || int'(addr) != a) stable = 0;
        end
        rdy = 1; tick(); rdy = 0;
        if (sm == 1) begin
            if (w) wr_sync = 1; else rd_sync = 1;
            tick();
            wr_sync = 0; rd_sync = 0;
        end
        repeat (dn_dly) tick();
        done = 1;
        if (sm == 2) begin if (w) wr_sync = 1; else rd_sync = 1; end
        tick();
        done = 0; wr_sync = 0; rd_sync = 0;
    endtask

    initial begin
        bit w, s;
        int a, mism, fd0;
        rst_n = 0; wr_req = 1; rd_req = 1;
        repeat (3) tick();
        chk("rst_vld", vld, 0); chk("rst_wg", wr_grant, 0); chk("rst_rg", rd_grant, 0);
        chk("rst_we", we, 0); chk("rst_addr", addr, 0); chk("rst_fd", fd, 0);
        rst_n = 1;
        burst(0, 3, 0, w, a, s); chk("tie1_we", w, 1); chk("tie1_addr", a, 0);
        burst(0, 3, 0, w, a, s); chk("tie2_we", w, 0); chk("tie2_addr", a, 0);
        burst(0, 3, 0, w, a, s); chk("tie3_we", w, 1); chk("tie3_addr", a, 64);
        burst(0, 3, 0, w, a, s); chk("tie4_we", w, 0); chk("tie4_addr", a, 64);
        urgent = 1;
        burst(0, 1, 0, w, a, s); chk("urg_lastrd_we", w, 0); chk("urg_lastrd_addr", a, 128);
        urgent = 0; rd_req = 0;
        burst(0, 1, 0, w, a, s); chk("wonly_we", w, 1); chk("wonly_addr", a, 128);
        rd_req = 1; urgent = 1;
        burst(0, 1, 0, w, a, s); chk("urg_lastwr_we", w, 0); chk("urg_lastwr_addr", a, 192);
        rd_req = 0;
        burst(0, 1, 0, w, a, s); chk("urg_noreq_we", w, 1); chk("urg_noreq_addr", a, 192);
        urgent = 0; rd_req = 1;
        burst(0, 1, 0, w, a, s); chk("rr_rd_we", w, 0); chk("rr_rd_addr", a, 256);
        wr_req = 0; mism = 0;
        for (int i = 0; i < 15; i++) begin
            burst(0, 1, 0, w, a, s);
            if (w || a != 320 + 64 * i) mism++;
        end
        chk("rd_run", mism, 0);
        burst(7, 2, 1, w, a, s);
        chk("stall_addr", a, 1280); chk("stall_stable", s, 1); chk("stall_we", w, 0);
        burst(0, 2, 0, w, a, s); chk("sync_busy_addr", a, 0);
        burst(0, 2, 2, w, a, s); chk("sync_done_addr", a, 64);
        burst(0, 2, 0, w, a, s); chk("after_sync_done", a, 0);
        rd_req = 0; wr_req = 1;
        burst(0, 2, 1, w, a, s); chk("wpend_addr", a, 256);
        burst(0, 2, 0, w, a, s); chk("wpend_next", a, 0);
        wr_req = 0;
        tick();
        wr_sync = 1; tick(); wr_sync = 0;
        done = 1; tick(); done = 0;
        tick();
        fd0 = fd_cnt; mism = 0; wr_req = 1;
        for (int i = 0; i < FP / BL; i++) begin
            burst(0, 0, 0, w, a, s);
            if (!w || a != i * BL) mism++;
        end
        chk("wrap_seq", mism, 0);
        chk("wrap_last", a, 307136);
        burst(0, 0, 0, w, a, s); chk("wrap_next", a, 0);
        chk("wrap_fd_cnt", fd_cnt - fd0, 1);
        tick();
        chk("abort_pre_vld", vld, 1);
        rst_n = 0; tick();
        chk("abort_vld", vld, 0); chk("abort_wg", wr_grant, 0);
        rst_n = 1; wr_req = 0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
